// File: rtl/cmp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : cmp_pkg
// Description : Shared constants and result encoding for comparator_1bit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package cmp_pkg;

    localparam int CNT_W_DEFAULT = 8;

    // One-hot result encoding packed as {g, l, e}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    function automatic logic [2:0] cmp_result(input logic a, input logic b);
        logic [2:0] res;
        res = RES_EQ;
        if (a && !b) begin
            res = RES_GT;
        end else if (!a && b) begin
            res = RES_LT;
        end
        return res;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/comparator_1bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : comparator_1bit
// Description : Registered 1-bit magnitude comparator with saturating
//               per-outcome statistics counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module comparator_1bit
    import cmp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cnt_clr,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic             out_valid,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] l_cnt,
    output logic [CNT_W-1:0] e_cnt
);

    logic [2:0] res_w;
    logic [2:0] res_q;
    logic [2:0] res_d;
    logic       out_valid_q;
    logic       out_valid_d;

    assign res_w = cmp_result(a, b);

    // Result holds across idle cycles; only out_valid drops.
    always_comb begin
        res_d       = res_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            res_d = res_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign g         = res_q[2];
    assign l         = res_q[1];
    assign e         = res_q[0];
    assign out_valid = out_valid_q;

    sat_counter #(.W(CNT_W)) u_g_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (in_valid & res_w[2]),
        .count (g_cnt)
    );

    sat_counter #(.W(CNT_W)) u_l_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (in_valid & res_w[1]),
        .count (l_cnt)
    );

    sat_counter #(.W(CNT_W)) u_e_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (in_valid & res_w[0]),
        .count (e_cnt)
    );

endmodule : comparator_1bit
`default_nettype wire

// File: tb/tb_comparator_1bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_comparator_1bit
// Description : Directed-vector bench for comparator_1bit (CNT_W = 2).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_comparator_1bit;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             g;
    logic             l;
    logic             e;
    logic             out_valid;
    logic [CNT_W-1:0] g_cnt;
    logic [CNT_W-1:0] l_cnt;
    logic [CNT_W-1:0] e_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    comparator_1bit #(.CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cnt_clr   (cnt_clr),
        .g         (g),
        .l         (l),
        .e         (e),
        .out_valid (out_valid),
        .g_cnt     (g_cnt),
        .l_cnt     (l_cnt),
        .e_cnt     (e_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic va, input logic vb, input logic clr);
        in_valid = v;
        a        = va;
        b        = vb;
        cnt_clr  = clr;
    endtask

    task automatic check_cnts(input string tag, input int eg, input int el, input int ee);
        check({tag, "_gcnt"}, 32'(g_cnt), 32'(eg));
        check({tag, "_lcnt"}, 32'(l_cnt), 32'(el));
        check({tag, "_ecnt"}, 32'(e_cnt), 32'(ee));
    endtask

    logic [2:0] sweep_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] sweep_b   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] sweep_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        check("rst_gle", {29'd0, g, l, e}, 32'h0);
        check("rst_ov", 32'(out_valid), 32'h0);
        check_cnts("rst", 0, 0, 0);
        rst = 1'b0;
        step();
        check("idle_ov", 32'(out_valid), 32'h0);

        // Exhaustive sweep, back-to-back valid samples
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sweep_a[i][0], sweep_b[i][0], 1'b0);
            step();
            check($sformatf("sweep%0d_gle", i), {29'd0, g, l, e}, 32'(sweep_exp[i]));
            check($sformatf("sweep%0d_ov", i), 32'(out_valid), 32'h1);
        end
        check_cnts("sweep", 1, 1, 2);

        // Hold behaviour
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("hold_load_gle", {29'd0, g, l, e}, 32'h4);
        check_cnts("hold_load", 2, 1, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_gle", i), {29'd0, g, l, e}, 32'h4);
            check($sformatf("hold%0d_ov", i), 32'(out_valid), 32'h0);
            check_cnts($sformatf("hold%0d", i), 2, 1, 2);
        end

        // Clear takes priority over the same-cycle increment
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check_cnts("clr", 0, 0, 0);
        check("clr_gle", {29'd0, g, l, e}, 32'h2);
        check("clr_ov", 32'(out_valid), 32'h1);

        // Saturation at 2^CNT_W-1 = 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            check($sformatf("sat%0d_ecnt", i), 32'(e_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("sat_gle", {29'd0, g, l, e}, 32'h1);
        check("sat_lcnt", 32'(l_cnt), 32'h0);

        // Reset mid-stream discards the accompanying sample
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check("mrst_gle", {29'd0, g, l, e}, 32'h0);
        check("mrst_ov", 32'(out_valid), 32'h0);
        check_cnts("mrst", 0, 0, 0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("post_gle", {29'd0, g, l, e}, 32'h1);
        check("post_ov", 32'(out_valid), 32'h1);
        check_cnts("post", 0, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("final_ov", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_comparator_1bit
`default_nettype wire
